// File: rtl/game_pkg.sv
// Shared types for the N x N board-game controller:
// cell codes, winner codes and controller states.
package game_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_X     = 2'b01,
      CELL_O     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_X    = 2'b01,
      WIN_O    = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   typedef enum logic [2:0] {
      IDLE,
      X_TURN,
      O_TURN,
      CHECK,
      DONE
   } state_t;

   function automatic cell_t moverCell(input logic t);
      return t ? CELL_O : CELL_X;
   endfunction

endpackage

// File: rtl/nxn_line_checker.sv
// Combinational win detector: counts the mover's run along the
// four lines through the last move, clipped to the grid.
module nxn_line_checker
   import game_pkg::*;
#(
   parameter int N  = 3,
   parameter int K  = 3,
   parameter int RW = $clog2(N)
) (
   input  logic [2*N*N-1:0] board,
   input  logic [RW-1:0]    lastRow,
   input  logic [RW-1:0]    lastCol,
   input  cell_t            mover,
   output logic             win
);

   int   dr;
   int   dc;
   int   run;
   int   rr;
   int   cc;
   logic fwdGo;
   logic bwdGo;

   function automatic logic [1:0] cellAt(
      input logic [2*N*N-1:0] b,
      input int               r,
      input int               c
   );
      logic [1:0] v;
      v = 2'b00;
      if (r >= 0 && r < N && c >= 0 && c < N)
         v = b[2*(r*N+c) +: 2];
      return v;
   endfunction

   // walk each direction both ways from the last move
   always_comb begin
      win   = 1'b0;
      dr    = 0;
      dc    = 0;
      run   = 0;
      rr    = 0;
      cc    = 0;
      fwdGo = 1'b0;
      bwdGo = 1'b0;
      for (int d = 0; d < 4; d++) begin
         dr    = (d == 0) ? 0 : 1;
         dc    = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
         run   = 1;
         fwdGo = 1'b1;
         bwdGo = 1'b1;
         for (int s = 1; s < K; s++) begin
            rr = int'(lastRow) + s*dr;
            cc = int'(lastCol) + s*dc;
            if (fwdGo && cellAt(board, rr, cc) == mover)
               run = run + 1;
            else
               fwdGo = 1'b0;
            rr = int'(lastRow) - s*dr;
            cc = int'(lastCol) - s*dc;
            if (bwdGo && cellAt(board, rr, cc) == mover)
               run = run + 1;
            else
               bwdGo = 1'b0;
         end
         if (run >= K)
            win = 1'b1;
      end
   end

endmodule

// File: rtl/nxn_board_game_ctrl.sv
// Two-player N x N, K-in-a-row controller with X/O alternation.
// Optional per-turn timeout: define GAME_MOVE_TIMEOUT_EN.
module nxn_board_game_ctrl
   import game_pkg::*;
#(
   parameter int N       = 3,
   parameter int K       = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 move_valid,
   input  logic [$clog2(N)-1:0] move_row,
   input  logic [$clog2(N)-1:0] move_col,
   output logic                 move_ready,
   output logic                 move_ack,
   output logic                 move_err,
   output logic                 turn,
   output logic [2*N*N-1:0]     board,
   output logic [1:0]           winner,
   output logic                 game_over,
   output logic                 timeout
);

   localparam int RW     = $clog2(N);
   localparam int CellsW = $clog2(N*N+1);
   localparam logic [CellsW-1:0] Cells = CellsW'(N*N);

   if (N < 3 || N > 8 || K < 3 || K > N || TIMEOUT < 1) begin : gBadParams
      $error("nxn_board_game_ctrl: illegal N, K or TIMEOUT");
   end

   state_t            state;
   state_t            stateNext;
   logic [CellsW-1:0] moveCnt;
   logic [RW-1:0]     lastRow;
   logic [RW-1:0]     lastCol;
   cell_t             moverNow;
   logic              inRange;
   logic              cellFree;
   logic              full;
   logic              accept;
   logic              reject;
   logic              toutFire;
   logic              expire;
   logic              lineWin;
   int                tgtIdx;

   assign moverNow = moverCell(turn);
   assign full     = (moveCnt == Cells);

   // legality of the requested cell
   always_comb begin
      inRange  = (int'(move_row) < N) && (int'(move_col) < N);
      tgtIdx   = inRange ? int'(move_row)*N + int'(move_col) : 0;
      cellFree = (board[2*tgtIdx +: 2] == CELL_EMPTY);
   end

   nxn_line_checker #(
      .N  (N),
      .K  (K),
      .RW (RW)
   ) uChecker (
      .board   (board),
      .lastRow (lastRow),
      .lastCol (lastCol),
      .mover   (moverNow),
      .win     (lineWin)
   );

`ifdef GAME_MOVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] turnCnt;
   logic          toutPulse;

   assign expire  = (turnCnt == TW'(TIMEOUT-1));
   assign timeout = toutPulse;

   // cycles spent in the current turn; zero outside a turn
   always_ff @(posedge clk) begin
      if (reset || start || !move_ready)
         turnCnt <= '0;
      else
         turnCnt <= turnCnt + 1'b1;
   end

   // one-cycle expiry pulse
   always_ff @(posedge clk) begin
      if (reset)
         toutPulse <= 1'b0;
      else
         toutPulse <= toutFire && !start;
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // next state, handshake decisions and status outputs
   always_comb begin
      stateNext  = state;
      accept     = 1'b0;
      reject     = 1'b0;
      toutFire   = 1'b0;
      move_ready = (state == X_TURN) || (state == O_TURN);
      game_over  = (state == DONE);
      if (start) begin
         stateNext = X_TURN;
      end else begin
         case (state)
            IDLE: stateNext = IDLE;
            X_TURN, O_TURN: begin
               if (move_valid && inRange && cellFree) begin
                  accept    = 1'b1;
                  stateNext = CHECK;
               end else begin
                  reject = move_valid;
                  if (expire) begin
                     toutFire  = 1'b1;
                     stateNext = DONE;
                  end
               end
            end
            CHECK: begin
               if (lineWin || full)
                  stateNext = DONE;
               else
                  stateNext = turn ? X_TURN : O_TURN;
            end
            DONE:    stateNext = DONE;
            default: stateNext = IDLE;
         endcase
      end
   end

   // board, counters, turn, result and pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         board    <= '0;
         moveCnt  <= '0;
         winner   <= WIN_NONE;
         turn     <= 1'b0;
         move_ack <= 1'b0;
         move_err <= 1'b0;
         lastRow  <= '0;
         lastCol  <= '0;
      end else begin
         move_ack <= accept;
         move_err <= reject;
         if (start) begin
            board   <= '0;
            moveCnt <= '0;
            winner  <= WIN_NONE;
            turn    <= 1'b0;
         end else begin
            if (accept) begin
               board[2*tgtIdx +: 2] <= moverNow;
               moveCnt <= moveCnt + 1'b1;
               lastRow <= move_row;
               lastCol <= move_col;
            end
            if (state == CHECK) begin
               if (lineWin)
                  winner <= turn ? WIN_O : WIN_X;
               else if (full)
                  winner <= WIN_DRAW;
               else
                  turn <= ~turn;
            end
            if (toutFire)
               winner <= turn ? WIN_X : WIN_O;
         end
      end
   end

endmodule

// File: tb/tb_nxn_board_game_ctrl.sv
// Directed bench for nxn_board_game_ctrl: a 3x3/K=3 and a 5x5/K=4
// instance driven from a move table plus a few hand sequences.
module tb_nxn_board_game_ctrl;

   logic clk = 1'b0;
   logic reset;

   logic        startA, validA;
   logic [1:0]  rowA, colA;
   logic        readyA, ackA, errA, turnA, overA, toutA;
   logic [17:0] boardA;
   logic [1:0]  winA;

   logic        startB, validB;
   logic [2:0]  rowB, colB;
   logic        readyB, ackB, errB, turnB, overB, toutB;
   logic [49:0] boardB;
   logic [1:0]  winB;

   always #5 clk = ~clk;

   nxn_board_game_ctrl #(.N(3), .K(3), .TIMEOUT(8)) dutA (
      .clk(clk), .reset(reset), .start(startA),
      .move_valid(validA), .move_row(rowA), .move_col(colA),
      .move_ready(readyA), .move_ack(ackA), .move_err(errA),
      .turn(turnA), .board(boardA), .winner(winA),
      .game_over(overA), .timeout(toutA)
   );

   nxn_board_game_ctrl #(.N(5), .K(4), .TIMEOUT(8)) dutB (
      .clk(clk), .reset(reset), .start(startB),
      .move_valid(validB), .move_row(rowB), .move_col(colB),
      .move_ready(readyB), .move_ack(ackB), .move_err(errB),
      .turn(turnB), .board(boardB), .winner(winB),
      .game_over(overB), .timeout(toutB)
   );

   typedef struct {
      bit         restart;
      bit         big;
      int         row;
      int         col;
      bit         expAck;
      bit         expErr;
      logic [1:0] expWin;
      bit         expTurn;
      bit         expOver;
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   logic [49:0] mBoard;
   bit          mTurn;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mv(bit rs, bit bg, int r, int c, bit a,
                               bit e, logic [1:0] w, bit t, bit o);
      vec_t v;
      v.restart = rs; v.big = bg; v.row = r; v.col = c;
      v.expAck = a; v.expErr = e; v.expWin = w;
      v.expTurn = t; v.expOver = o;
      return v;
   endfunction

   task automatic drive(input bit big, input bit s, input bit v,
                        input int r, input int c);
      if (big) begin
         startB = s; validB = v; rowB = r[2:0]; colB = c[2:0];
      end else begin
         startA = s; validA = v; rowA = r[1:0]; colA = c[1:0];
      end
   endtask

   task automatic doStart(input bit big);
      @(negedge clk);
      drive(big, 1'b1, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      drive(big, 1'b0, 1'b0, 0, 0);
      mBoard = '0;
      mTurn  = 1'b0;
   endtask

   task automatic applyVec(input vec_t v, input int i);
      int n;
      n = v.big ? 5 : 3;
      if (v.restart)
         doStart(v.big);
      @(negedge clk);
      drive(v.big, 1'b0, 1'b1, v.row, v.col);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.ack", i), v.big ? ackB : ackA, v.expAck);
      check($sformatf("v%0d.err", i), v.big ? errB : errA, v.expErr);
      @(negedge clk);
      drive(v.big, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      if (v.expAck)
         mBoard[2*(v.row*n+v.col) +: 2] = mTurn ? 2'b10 : 2'b01;
      check($sformatf("v%0d.winner", i), v.big ? winB : winA, v.expWin);
      check($sformatf("v%0d.over", i), v.big ? overB : overA, v.expOver);
      check($sformatf("v%0d.turn", i), v.big ? turnB : turnA, v.expTurn);
      check($sformatf("v%0d.board", i),
            v.big ? boardB : {32'b0, boardA}, mBoard);
      mTurn = v.expTurn;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      mBoard = '0;
      mTurn  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.readyA", readyA, 1'b0);
      check("rst.boardA", boardA, 18'h0);
      check("rst.winA", winA, 2'b00);
      check("rst.turnA", turnA, 1'b0);
      check("rst.overA", overA, 1'b0);
      check("rst.pulsesA", {ackA, errA, toutA}, 3'b000);
      check("rst.readyB", readyB, 1'b0);
      check("rst.boardB", boardB, 50'h0);
      @(negedge clk);
      reset = 1'b0;

      // a move request while idle is ignored
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1, 1);
      @(posedge clk);
      #1;
      check("idle.ack", ackA, 1'b0);
      check("idle.err", errA, 1'b0);
      check("idle.board", boardA, 18'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 0, 0);

      // 3x3 top-row win for X, later move ignored
      vecs.push_back(mv(1, 0, 0, 0, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 0, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 0, 1, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 1, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 0, 2, 1, 0, 2'b01, 0, 1));
      vecs.push_back(mv(0, 0, 2, 2, 0, 0, 2'b01, 0, 1));
      // occupied cell and out-of-range on 3x3
      vecs.push_back(mv(1, 0, 1, 1, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 1, 0, 1, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 2, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 3, 0, 0, 1, 2'b00, 0, 0));
      // 3x3 draw
      vecs.push_back(mv(1, 0, 0, 0, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 0, 2, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 1, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 1, 0, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 1, 2, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 2, 1, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 0, 2, 0, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 0, 2, 2, 1, 0, 2'b11, 0, 1));
      // 5x5, K=4: O diagonal, 3-run is not yet a win
      vecs.push_back(mv(1, 1, 0, 0, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 1, 1, 1, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 1, 0, 2, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 1, 2, 2, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 1, 0, 4, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 1, 3, 3, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mv(0, 1, 2, 0, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mv(0, 1, 4, 4, 1, 0, 2'b10, 1, 1));
      // 5x5 out of range
      vecs.push_back(mv(1, 1, 6, 0, 0, 1, 2'b00, 0, 0));
      vecs.push_back(mv(0, 1, 0, 5, 0, 1, 2'b00, 0, 0));
      vecs.push_back(mv(0, 1, 2, 2, 1, 0, 2'b00, 1, 0));

      foreach (vecs[i])
         applyVec(vecs[i], i);

      // start and move on the same edge: start wins, move dropped
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 0, 0);
      @(posedge clk);
      #1;
      check("sv.ack", ackB, 1'b0);
      check("sv.err", errB, 1'b0);
      check("sv.board", boardB, 50'h0);
      check("sv.turn", turnB, 1'b0);
      check("sv.ready", readyB, 1'b1);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      check("sv.ack2", ackB, 1'b0);
      check("sv.board2", boardB, 50'h0);

      // reset mid-game overrides everything
      doStart(1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid.board", boardA, 18'h1);
      check("mid.turn", turnA, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1, 1);
      @(posedge clk);
      #1;
      check("mrst.board", boardA, 18'h0);
      check("mrst.ready", readyA, 1'b0);
      check("mrst.turn", turnA, 1'b0);
      check("mrst.win", winA, 2'b00);
      check("mrst.pulses", {ackA, errA, toutA, overA}, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 0);

`ifdef GAME_MOVE_TIMEOUT_EN
      // X idles for TIMEOUT cycles: O wins by timeout
      doStart(1'b0);
      repeat (6) @(posedge clk);
      @(posedge clk);
      #1;
      check("to.early", toutA, 1'b0);
      check("to.earlyOver", overA, 1'b0);
      @(posedge clk);
      #1;
      check("to.pulse", toutA, 1'b1);
      check("to.win", winA, 2'b10);
      check("to.over", overA, 1'b1);
      check("to.ready", readyA, 1'b0);
      @(posedge clk);
      #1;
      check("to.pulseEnd", toutA, 1'b0);
      check("to.hold", winA, 2'b10);
`else
      // without the timeout feature an idle turn never expires
      doStart(1'b0);
      repeat (12) @(posedge clk);
      #1;
      check("nto.tout", toutA, 1'b0);
      check("nto.over", overA, 1'b0);
      check("nto.ready", readyA, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
